// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine (gcd_unit / gcd_datapath).
package gcd_pkg;

  localparam int GCD_WIDTH_DEF = 16;
  localparam int GCD_CNT_W_DEF = 8;
  localparam int GCD_STATE_W   = 2;

  typedef enum logic [GCD_STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_datapath.sv
// GCD operand registers, comparator, subtractor and (with GCD_BINARY_EN) Stein shifters.
// The result output is only meaningful in the cycle the zero/eq flags end the run.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] a_nxt_s;
  logic [WIDTH-1:0] b_nxt_s;

  // Operand comparator flags.
  always_comb begin
    zero = (a_r == {WIDTH{1'b0}}) || (b_r == {WIDTH{1'b0}});
    eq   = (a_r == b_r);
    gt   = (a_r > b_r);
    lt   = (a_r < b_r);
  end

`ifdef GCD_BINARY_EN
  localparam int K_W = $clog2(WIDTH) + 1;
  localparam logic [K_W-1:0] K_ONE = {{(K_W-1){1'b0}}, 1'b1};

  logic [K_W-1:0] k_r;
  logic [K_W-1:0] k_nxt_s;

  // Stein step: common factors of two move into k, odd pairs subtract.
  always_comb begin
    a_nxt_s = a_r;
    b_nxt_s = b_r;
    k_nxt_s = k_r;
    if (!a_r[0] && !b_r[0]) begin
      a_nxt_s = {1'b0, a_r[WIDTH-1:1]};
      b_nxt_s = {1'b0, b_r[WIDTH-1:1]};
      k_nxt_s = k_r + K_ONE;
    end else if (!a_r[0]) begin
      a_nxt_s = {1'b0, a_r[WIDTH-1:1]};
    end else if (!b_r[0]) begin
      b_nxt_s = {1'b0, b_r[WIDTH-1:1]};
    end else if (gt) begin
      a_nxt_s = a_r - b_r;
    end else if (lt) begin
      b_nxt_s = b_r - a_r;
    end else begin
      a_nxt_s = a_r;
      b_nxt_s = b_r;
    end
  end

  // Shift counter, cleared when a new pair is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r <= {K_W{1'b0}};
    end else if (load) begin
      k_r <= {K_W{1'b0}};
    end else if (step) begin
      k_r <= k_nxt_s;
    end else begin
      k_r <= k_r;
    end
  end

  // A|B equals A when A==B, so one expression covers both terminal cases.
  assign result = (a_r | b_r) << k_r;
`else
  // Subtractive step: larger operand is always the minuend.
  always_comb begin
    a_nxt_s = a_r;
    b_nxt_s = b_r;
    if (gt) begin
      a_nxt_s = a_r - b_r;
    end else if (lt) begin
      b_nxt_s = b_r - a_r;
    end else begin
      a_nxt_s = a_r;
      b_nxt_s = b_r;
    end
  end

  assign result = a_r | b_r;
`endif

  // Operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= {WIDTH{1'b0}};
      b_r <= {WIDTH{1'b0}};
    end else if (load) begin
      a_r <= a_in;
      b_r <= b_in;
    end else if (step) begin
      a_r <= a_nxt_s;
      b_r <= b_nxt_s;
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// Parametrised GCD engine with start/busy/done handshake and saturating iteration count.
// Define GCD_BINARY_EN to build the datapath with Stein's binary algorithm.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEF,
  parameter int CNT_W = GCD_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  gcd_state_e       state_r;
  logic             load_s;
  logic             step_s;
  logic             fin_s;
  logic [WIDTH-1:0] result_s;
  logic             zero_s;
  logic             eq_s;
  logic             gt_s;
  logic             lt_s;

  // Accept/advance strobes; a comparator with neither gt nor lt also ends the run.
  always_comb begin
    load_s = (state_r == IDLE) && start;
    fin_s  = zero_s || eq_s || (!gt_s && !lt_s);
    step_s = (state_r == CALC) && !fin_s;
  end

  gcd_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .step   (step_s),
    .a_in   (a_in),
    .b_in   (b_in),
    .result (result_s),
    .zero   (zero_s),
    .eq     (eq_s),
    .gt     (gt_s),
    .lt     (lt_s)
  );

  // Controller FSM with registered handshake, result and iteration count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      gcd_out  <= {WIDTH{1'b0}};
      iter_cnt <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (load_s) begin
            state_r  <= CALC;
            busy     <= 1'b1;
            iter_cnt <= {CNT_W{1'b0}};
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        CALC: begin
          busy <= 1'b1;
          if (iter_cnt != CNT_MAX) begin
            iter_cnt <= iter_cnt + CNT_ONE;
          end else begin
            iter_cnt <= iter_cnt;
          end
          if (fin_s) begin
            gcd_out <= result_s;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            done    <= 1'b0;
            state_r <= CALC;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: vector table, handshake corner cases and random sweep.
module tb_gcd_unit;

  localparam int LIMIT = 700;
`ifdef GCD_BINARY_EN
  localparam bit BIN = 1'b1;
`else
  localparam bit BIN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start8;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy, done, busy8, done8;
  logic [15:0] gcd16;
  logic [7:0]  iter16, gcd8, iter8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gcd_unit #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .gcd_out(gcd16), .iter_cnt(iter16)
  );

  gcd_unit #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a_in[7:0]), .b_in(b_in[7:0]),
    .busy(busy8), .done(done8), .gcd_out(gcd8), .iter_cnt(iter8)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
    logic [7:0]  it;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference GCD by Euclid's remainder method.
  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // CALC cycles needed: subtractive = sum of Euclid quotients; binary = Stein step count.
  function automatic int ref_iters(input int a, input int b);
    int n;
    int t;
    if (a == 0 || b == 0) return 1;
    n = 0;
    if (BIN) begin
      n = 1;
      while (a != b) begin
        if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
        else if (a % 2 == 0) a = a / 2;
        else if (b % 2 == 0) b = b / 2;
        else if (a > b) a = a - b;
        else b = b - a;
        n++;
      end
    end else begin
      while (b != 0) begin
        n = n + a / b;
        t = a % b;
        a = b;
        b = t;
      end
    end
    return n;
  endfunction

  task automatic wait_done(input logic use8, output int lat, output logic ok, output logic bz);
    lat = 0;
    ok  = 1'b0;
    bz  = 1'b1;
    for (int c = 1; c <= LIMIT; c++) begin
      if (use8 ? !busy8 : !busy) bz = 1'b0;
      if (use8 ? done8 : done) begin
        lat = c;
        ok  = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input logic use8, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] g, output logic [7:0] it, output int lat,
                        output logic ok, output logic bz, output logic once);
    a_in = a;
    b_in = b;
    if (use8) start8 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start8 = 1'b0;
    wait_done(use8, lat, ok, bz);
    g  = use8 ? {8'h00, gcd8} : gcd16;
    it = use8 ? iter8 : iter16;
    @(posedge clk); #1;
    once = use8 ? (!done8 && !busy8) : (!done && !busy);
  endtask

  task automatic check_op(input string nm, input logic use8, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] eg, input int en);
    logic [15:0] g;
    logic [7:0]  it;
    int          lat;
    logic        ok, bz, once;
    run_op(use8, a, b, g, it, lat, ok, bz, once);
    chk({nm, "_done_seen"}, 32'(ok), 32'd1);
    chk({nm, "_gcd"}, 32'(g), 32'(eg));
    chk({nm, "_iter"}, 32'(it), (en > 255) ? 32'd255 : 32'(en));
    chk({nm, "_latency"}, 32'(lat), 32'(en + 1));
    chk({nm, "_busy_held"}, 32'(bz), 32'd1);
    chk({nm, "_single_done"}, 32'(once), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic ok, bz, seen;
    int   ra, rb;

    vt[0] = '{16'd12,  16'd8,  16'd4,  BIN ? 8'd6 : 8'd3};
    vt[1] = '{16'd0,   16'd9,  16'd9,  8'd1};
    vt[2] = '{16'd0,   16'd0,  16'd0,  8'd1};
    vt[3] = '{16'd9,   16'd0,  16'd9,  8'd1};
    vt[4] = '{16'd7,   16'd7,  16'd7,  8'd1};
    vt[5] = '{16'd48,  16'd18, 16'd6,  BIN ? 8'd7 : 8'd5};
    vt[6] = '{16'd100, 16'd75, 16'd25, BIN ? 8'd5 : 8'd4};

    rst = 1'b1; start = 1'b0; start8 = 1'b0; a_in = 16'd0; b_in = 16'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_gcd", 32'(gcd16), 32'd0);
    chk("rst_iter", 32'(iter16), 32'd0);
    chk("rst8_busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      check_op("vec", 1'b0, vt[i].a, vt[i].b, vt[i].g, int'(vt[i].it));

    // Long runs: 8-bit worst case and 16-bit count saturation.
    check_op("w8_255_1", 1'b1, 16'd255, 16'd1, 16'd1, BIN ? 15 : 255);
    check_op("sat_600_1", 1'b0, 16'd600, 16'd1, 16'd1, ref_iters(600, 1));

    // start held high through a run; only the first is accepted, next after DONE.
    a_in = 16'd48; b_in = 16'd18; start = 1'b1;
    @(posedge clk); #1;
    a_in = 16'd5; b_in = 16'd3;
    wait_done(1'b0, lat, ok, bz);
    chk("hold_done_seen", 32'(ok), 32'd1);
    chk("hold_gcd", 32'(gcd16), 32'd6);
    chk("hold_iter", 32'(iter16), 32'(ref_iters(48, 18)));
    chk("hold_latency", 32'(lat), 32'(ref_iters(48, 18) + 1));
    @(posedge clk); #1;
    chk("hold_idle_gap_busy", 32'(busy), 32'd0);
    chk("hold_idle_gap_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("hold_reaccept_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(1'b0, lat, ok, bz);
    chk("hold2_gcd", 32'(gcd16), 32'd1);
    chk("hold2_iter", 32'(iter16), 32'(ref_iters(5, 3)));
    @(posedge clk); #1;

    // Reset two cycles into a run aborts it with no done strobe.
    check_op("pre_rst", 1'b0, 16'd100, 16'd75, 16'd25, BIN ? 5 : 4);
    a_in = 16'd100; b_in = 16'd75; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_gcd", 32'(gcd16), 32'd0);
    chk("abort_iter", 32'(iter16), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_activity", 32'(seen), 32'd0);
    check_op("post_rst", 1'b0, 16'd100, 16'd75, 16'd25, BIN ? 5 : 4);

    // Random sweeps against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = int'($urandom_range(0, 127));
      rb = (i % 50 == 7) ? 0 : int'($urandom_range(0, 127));
      check_op("rnd16", 1'b0, 16'(ra), 16'(rb), 16'(ref_gcd(ra, rb)), ref_iters(ra, rb));
    end
    for (int i = 0; i < 200; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      check_op("rnd8", 1'b1, 16'(ra), 16'(rb), 16'(ref_gcd(ra, rb)), ref_iters(ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
